// File: rtl/intpol2_d4_job_sched.sv
// ---------------------------------------------------------------------------
// intpol2_d4_job_sched
//
// Shares one intpol2_D4 interpolator core between two requesters. Pending
// requests are arbitrated round-robin. The winner's job configuration is
// latched and driven to the core, and the core is launched with a one-cycle
// start pulse. A watchdog then tracks the core's busy/done handshake, and a
// completion or timeout pulse is returned to the requester that owns the job.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req[1:0]              per-requester job request (level, held until ack)
//   ilen0/1, mode0/1,
//   bypass0/1             per-requester job configuration
//   ack[1:0]              one-cycle pulse: job accepted from requester i
//   done_o[1:0]           one-cycle pulse: job of requester i completed
//   err_o[1:0]            one-cycle pulse: job of requester i timed out
//   tmo_cycles            watchdog limit in cycles, 0 disables the watchdog
//   core_start            one-cycle start pulse to the core
//   core_ilen/mode/bypass latched job configuration driven to the core
//   core_busy, core_done  handshake from the core
//   owner                 requester owning the current job (valid while busy)
//   sched_busy            high in every state except IDLE
//   job_cnt               completed-job counter (done and zero-length jobs)
// ---------------------------------------------------------------------------
module intpol2_d4_job_sched #(
  parameter int DATA_WIDTH = 32,
  parameter int TMO_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req,
  input  logic [DATA_WIDTH:0]   ilen0,
  input  logic [DATA_WIDTH:0]   ilen1,
  input  logic                  mode0,
  input  logic                  mode1,
  input  logic                  bypass0,
  input  logic                  bypass1,
  output logic [1:0]            ack,
  output logic [1:0]            done_o,
  output logic [1:0]            err_o,
  input  logic [TMO_W-1:0]      tmo_cycles,
  output logic                  core_start,
  output logic [DATA_WIDTH:0]   core_ilen,
  output logic                  core_mode,
  output logic                  core_bypass,
  input  logic                  core_busy,
  input  logic                  core_done,
  output logic                  owner,
  output logic                  sched_busy,
  output logic [15:0]           job_cnt
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LAUNCH    = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;
  localparam logic [2:0] ST_ABORT     = 3'd5;

  logic [2:0]          state_q,      state_d;
  logic [1:0]          ack_q,        ack_d;
  logic [1:0]          done_q,       done_d;
  logic [1:0]          err_q,        err_d;
  logic                start_q,      start_d;
  logic [DATA_WIDTH:0] ilen_q,       ilen_d;
  logic                mode_q,       mode_d;
  logic                bypass_q,     bypass_d;
  logic                owner_q,      owner_d;
  logic                sched_busy_q, sched_busy_d;
  logic [15:0]         job_cnt_q,    job_cnt_d;
  logic [TMO_W-1:0]    timer_q,      timer_d;
  logic                last_q,       last_d;

  logic                win;
  logic [DATA_WIDTH:0] win_ilen;
  logic [TMO_W-1:0]    timer_inc;
  logic                tmo_hit;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    ack_d     = '0;
    done_d    = '0;
    err_d     = '0;
    start_d   = 1'b0;
    ilen_d    = ilen_q;
    mode_d    = mode_q;
    bypass_d  = bypass_q;
    owner_d   = owner_q;
    job_cnt_d = job_cnt_q;
    timer_d   = timer_q;
    last_d    = last_q;

    // On a tie the requester that did not win last time is served.
    win      = (req == 2'b11) ? ~last_q : req[1];
    win_ilen = win ? ilen1 : ilen0;

    // The timer value including the current cycle is compared, so a limit of
    // N produces err_o N+1 cycles after the start pulse. It saturates.
    timer_inc = (&timer_q) ? timer_q : timer_q + TMO_W'(1);
    tmo_hit   = (tmo_cycles != '0) && (timer_inc >= tmo_cycles);

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          owner_d    = win;
          last_d     = win;
          ilen_d     = win_ilen;
          mode_d     = win ? mode1 : mode0;
          bypass_d   = win ? bypass1 : bypass0;
          ack_d[win] = 1'b1;
          start_d    = (win_ilen != '0);
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = '0;
        if (ilen_q == '0) begin
          // Zero-length job: the core is never started, report completion.
          done_d[owner_q] = 1'b1;
          job_cnt_d       = job_cnt_q + 16'd1;
          state_d         = ST_FINISH;
        end else begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY, ST_RUN: begin
        timer_d = timer_inc;
        // done beats a simultaneous timeout; a timeout beats busy so the
        // abort latency does not depend on when the core raised busy.
        if (core_done) begin
          done_d[owner_q] = 1'b1;
          job_cnt_d       = job_cnt_q + 16'd1;
          state_d         = ST_FINISH;
        end else if (tmo_hit) begin
          err_d[owner_q] = 1'b1;
          state_d        = ST_ABORT;
        end else if (state_q == ST_WAIT_BUSY && core_busy) begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      ST_ABORT:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    sched_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ack_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      start_q      <= 1'b0;
      ilen_q       <= '0;
      mode_q       <= 1'b0;
      bypass_q     <= 1'b0;
      owner_q      <= 1'b0;
      sched_busy_q <= 1'b0;
      job_cnt_q    <= '0;
      timer_q      <= '0;
      last_q       <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q      <= state_d;
      ack_q        <= ack_d;
      done_q       <= done_d;
      err_q        <= err_d;
      start_q      <= start_d;
      ilen_q       <= ilen_d;
      mode_q       <= mode_d;
      bypass_q     <= bypass_d;
      owner_q      <= owner_d;
      sched_busy_q <= sched_busy_d;
      job_cnt_q    <= job_cnt_d;
      timer_q      <= timer_d;
      last_q       <= last_d;
    end
  end

  assign ack         = ack_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign core_start  = start_q;
  assign core_ilen   = ilen_q;
  assign core_mode   = mode_q;
  assign core_bypass = bypass_q;
  assign owner       = owner_q;
  assign sched_busy  = sched_busy_q;
  assign job_cnt     = job_cnt_q;

endmodule
